// File: rtl/vx_wb_scoreboard_if.sv
// Bundle of the ibuffer-side, dispatch-side and writeback-side signals of the
// writeback scoreboard; slave is the scoreboard, master is whoever drives it.
interface vx_wb_scoreboard_if #(
  parameter int NUM_WIS  = 4,
  parameter int NUM_REGS = 64,
  parameter int STALL_W  = 16
);
  localparam int WIS_W = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1;
  localparam int NR_W  = $clog2(NUM_REGS);

  logic               ibuf_valid;
  logic [WIS_W-1:0]   ibuf_wis;
  logic               ibuf_wb;
  logic [NR_W-1:0]    ibuf_rd;
  logic [NR_W-1:0]    ibuf_rs1;
  logic [NR_W-1:0]    ibuf_rs2;
  logic [NR_W-1:0]    ibuf_rs3;
  logic               ibuf_ready;

  logic               issue_valid;
  logic [WIS_W-1:0]   issue_wis;
  logic               issue_wb;
  logic [NR_W-1:0]    issue_rd;
  logic               issue_ready;

  logic               wb_valid;
  logic [WIS_W-1:0]   wb_wis;
  logic [NR_W-1:0]    wb_rd;
  logic               wb_eop;

  logic [NUM_WIS-1:0] wis_pending;
  logic [STALL_W-1:0] stall_cycles;

  modport slave (
    input  ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    output ibuf_ready,
    output issue_valid, issue_wis, issue_wb, issue_rd,
    input  issue_ready,
    input  wb_valid, wb_wis, wb_rd, wb_eop,
    output wis_pending, stall_cycles
  );

  modport master (
    output ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    input  ibuf_ready,
    input  issue_valid, issue_wis, issue_wb, issue_rd,
    output issue_ready,
    output wb_valid, wb_wis, wb_rd, wb_eop,
    input  wis_pending, stall_cycles
  );
endinterface

// File: rtl/vx_wb_scoreboard.sv
// Per-warp register scoreboard: stalls issue on RAW/WAW against pending writes,
// releases on the eop writeback beat, and feeds dispatch through a 1-entry register.
module vx_wb_scoreboard #(
  parameter int NUM_WIS  = 4,
  parameter int NUM_REGS = 64,
  parameter int CNT_W    = 4,
  parameter int STALL_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_wb_scoreboard_if.slave    bus
);
  localparam int WIS_W = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1;

  logic [NUM_REGS-1:0] busy [NUM_WIS];
  logic [CNT_W-1:0]    cnt  [NUM_WIS];

  logic [NUM_REGS-1:0] ibuf_busy;
  logic [NUM_REGS-1:0] wb_busy;
  logic                hazard;
  logic                accept;
  logic                set_en;
  logic                rel_en;
  logic [NUM_WIS-1:0]  inc;
  logic [NUM_WIS-1:0]  dec;

  assign ibuf_busy = busy[bus.ibuf_wis];
  assign wb_busy   = busy[bus.wb_wis];

  // A full in-flight counter blocks further writers of that warp like a WAW.
  always_comb begin
    hazard = ibuf_busy[bus.ibuf_rs1] | ibuf_busy[bus.ibuf_rs2] | ibuf_busy[bus.ibuf_rs3] |
             (bus.ibuf_wb & (ibuf_busy[bus.ibuf_rd] | (cnt[bus.ibuf_wis] == '1)));
  end

  assign bus.ibuf_ready = !reset & bus.ibuf_valid & !hazard &
                          (!bus.issue_valid | bus.issue_ready);
  assign accept = bus.ibuf_ready;
  assign set_en = accept & bus.ibuf_wb & (bus.ibuf_rd != '0);
  // Only a busy entry can be released, so set and release never hit the same bit.
  assign rel_en = bus.wb_valid & bus.wb_eop & wb_busy[bus.wb_rd] & (cnt[bus.wb_wis] != '0);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned w = 0; w < NUM_WIS; w++) begin
      inc[w] = set_en & (bus.ibuf_wis == WIS_W'(w));
      dec[w] = rel_en & (bus.wb_wis == WIS_W'(w));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WIS; w++) begin
        busy[w] <= '0;
        cnt[w]  <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WIS; w++) begin
        if (inc[w]) busy[w][bus.ibuf_rd] <= 1'b1;
        if (dec[w]) busy[w][bus.wb_rd]   <= 1'b0;
        if (inc[w] && !dec[w])      cnt[w] <= cnt[w] + 1'b1;
        else if (dec[w] && !inc[w]) cnt[w] <= cnt[w] - 1'b1;
      end
    end
  end

  always_comb begin
    bus.wis_pending = '0;
    for (int unsigned w = 0; w < NUM_WIS; w++) begin
      bus.wis_pending[w] = (cnt[w] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.issue_valid <= 1'b0;
      bus.issue_wis   <= '0;
      bus.issue_wb    <= 1'b0;
      bus.issue_rd    <= '0;
    end else if (accept) begin
      bus.issue_valid <= 1'b1;
      bus.issue_wis   <= bus.ibuf_wis;
      bus.issue_wb    <= bus.ibuf_wb;
      bus.issue_rd    <= bus.ibuf_rd;
    end else if (bus.issue_ready) begin
      bus.issue_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_cycles <= '0;
    end else if (bus.ibuf_valid && hazard && (bus.stall_cycles != '1)) begin
      bus.stall_cycles <= bus.stall_cycles + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && bus.wb_valid && bus.wb_eop) begin
      assert (wb_busy[bus.wb_rd])
        else $warning("writeback release of idle register wis=%0d rd=%0d", bus.wb_wis, bus.wb_rd);
    end
  end
`endif
endmodule

// File: tb/tb_vx_wb_scoreboard.sv
// Directed self-checking bench for vx_wb_scoreboard with hand-computed expectations.
module tb_vx_wb_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vx_wb_scoreboard_if #(.NUM_WIS(4), .NUM_REGS(64), .STALL_W(16)) bus ();

  vx_wb_scoreboard #(.NUM_WIS(4), .NUM_REGS(64), .CNT_W(4), .STALL_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle();
    bus.ibuf_valid  = 1'b0;
    bus.ibuf_wis    = '0;
    bus.ibuf_wb     = 1'b0;
    bus.ibuf_rd     = '0;
    bus.ibuf_rs1    = '0;
    bus.ibuf_rs2    = '0;
    bus.ibuf_rs3    = '0;
    bus.issue_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_wis      = '0;
    bus.wb_rd       = '0;
    bus.wb_eop      = 1'b0;
  endtask

  task automatic drive_instr(input int w, input int wb, input int rd,
                             input int rs1, input int rs2, input int rs3);
    bus.ibuf_valid = 1'b1;
    bus.ibuf_wis   = 2'(w);
    bus.ibuf_wb    = 1'(wb);
    bus.ibuf_rd    = 6'(rd);
    bus.ibuf_rs1   = 6'(rs1);
    bus.ibuf_rs2   = 6'(rs2);
    bus.ibuf_rs3   = 6'(rs3);
  endtask

  task automatic drive_wb(input int w, input int rd, input int eop);
    bus.wb_valid = 1'b1;
    bus.wb_wis   = 2'(w);
    bus.wb_rd    = 6'(rd);
    bus.wb_eop   = 1'(eop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    drive_instr(0, 1, 3, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ibuf_ready); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", bus.wis_pending); end
    checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_raw();
    @(negedge clk); drive_instr(0, 1, 5, 0, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready got=%b exp=1", bus.ibuf_ready); end
    @(negedge clk); drive_instr(0, 0, 0, 5, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready got=%b exp=0", bus.ibuf_ready); end
    checks++; if (bus.issue_rd !== 6'd5 || bus.issue_wb !== 1'b1 || bus.issue_valid !== 1'b1) begin
      errors++; $display("FAIL raw_issue got v=%b wb=%b rd=%0d exp v=1 wb=1 rd=5", bus.issue_valid, bus.issue_wb, bus.issue_rd); end
    checks++; if (bus.wis_pending !== 4'b0001) begin errors++; $display("FAIL raw_pending got=%b exp=0001", bus.wis_pending); end
    @(negedge clk); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL raw_stall2_ready got=%b exp=0", bus.ibuf_ready); end
    @(negedge clk); drive_wb(0, 5, 1); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got=%b exp=0", bus.ibuf_ready); end
    @(negedge clk); bus.wb_valid = 1'b0; #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL raw_release_ready got=%b exp=1", bus.ibuf_ready); end
    checks++; if (bus.stall_cycles !== 16'd3) begin errors++; $display("FAIL raw_stall_count got=%0d exp=3", bus.stall_cycles); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL raw_pending_clear got=%b exp=0000", bus.wis_pending); end
  endtask

  task automatic test_multibeat();
    @(negedge clk); idle(); drive_instr(1, 1, 7, 0, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL mb_first_ready got=%b exp=1", bus.ibuf_ready); end
    @(negedge clk); drive_instr(1, 0, 0, 0, 7, 0); drive_wb(1, 7, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL mb_stall_ready got=%b exp=0", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0010) begin errors++; $display("FAIL mb_pending got=%b exp=0010", bus.wis_pending); end
    @(negedge clk); drive_wb(1, 7, 1); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL mb_sop_ignored got=%b exp=0", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0010) begin errors++; $display("FAIL mb_pending_sop got=%b exp=0010", bus.wis_pending); end
    @(negedge clk); bus.wb_valid = 1'b0; #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL mb_eop_ready got=%b exp=1", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL mb_pending_clear got=%b exp=0000", bus.wis_pending); end
    checks++; if (bus.stall_cycles !== 16'd5) begin errors++; $display("FAIL mb_stall_count got=%0d exp=5", bus.stall_cycles); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); drive_instr(i, 1, 10 + i, 0, 0, 0); #1;
      checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.ibuf_ready); end
      if (i > 0) begin
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_wis !== 2'(i - 1) || bus.issue_rd !== 6'(10 + i - 1)) begin
          errors++; $display("FAIL b2b_issue[%0d] got v=%b wis=%0d rd=%0d exp v=1 wis=%0d rd=%0d",
                             i, bus.issue_valid, bus.issue_wis, bus.issue_rd, i - 1, 10 + i - 1); end
      end
    end
    @(negedge clk); idle(); #1;
    checks++; if (bus.issue_wis !== 2'd3 || bus.issue_rd !== 6'd13) begin
      errors++; $display("FAIL b2b_last_issue got wis=%0d rd=%0d exp wis=3 rd=13", bus.issue_wis, bus.issue_rd); end
    checks++; if (bus.wis_pending !== 4'b1111) begin errors++; $display("FAIL b2b_pending got=%b exp=1111", bus.wis_pending); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_wb(i, 10 + i, 1);
    end
    @(negedge clk); idle(); #1;
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL b2b_pending_clear got=%b exp=0000", bus.wis_pending); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue_drain got=%b exp=0", bus.issue_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); drive_instr(0, 1, 20, 0, 0, 0); bus.issue_ready = 1'b0; #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got=%b exp=1", bus.ibuf_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive_instr(1, 1, 21, 0, 0, 0); #1;
      checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, bus.ibuf_ready); end
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_wis !== 2'd0 || bus.issue_rd !== 6'd20 || bus.issue_wb !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b wis=%0d rd=%0d wb=%b exp v=1 wis=0 rd=20 wb=1",
                           k, bus.issue_valid, bus.issue_wis, bus.issue_rd, bus.issue_wb); end
    end
    @(negedge clk); bus.issue_ready = 1'b1; #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got=%b exp=1", bus.ibuf_ready); end
    checks++; if (bus.stall_cycles !== 16'd5) begin errors++; $display("FAIL bp_stall_count got=%0d exp=5", bus.stall_cycles); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.issue_wis !== 2'd1 || bus.issue_rd !== 6'd21) begin
      errors++; $display("FAIL bp_second_issue got wis=%0d rd=%0d exp wis=1 rd=21", bus.issue_wis, bus.issue_rd); end
    checks++; if (bus.wis_pending !== 4'b0011) begin errors++; $display("FAIL bp_pending got=%b exp=0011", bus.wis_pending); end
    @(negedge clk); drive_wb(0, 20, 1);
    @(negedge clk); drive_wb(1, 21, 1);
    @(negedge clk); idle(); #1;
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL bp_pending_clear got=%b exp=0000", bus.wis_pending); end
  endtask

  task automatic test_cnt_full_and_reset();
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); drive_instr(2, 1, i, 0, 0, 0); #1;
      checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL cnt_fill_ready[%0d] got=%b exp=1", i, bus.ibuf_ready); end
    end
    @(negedge clk); drive_instr(2, 1, 16, 0, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL cnt_full_stall got=%b exp=0", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0100) begin errors++; $display("FAIL cnt_pending got=%b exp=0100", bus.wis_pending); end
    @(negedge clk); #1;
    checks++; if (bus.stall_cycles !== 16'd6) begin errors++; $display("FAIL cnt_stall_count got=%0d exp=6", bus.stall_cycles); end
    checks++; if (bus.issue_rd !== 6'd15 || bus.issue_wis !== 2'd2) begin
      errors++; $display("FAIL cnt_last_issue got wis=%0d rd=%0d exp wis=2 rd=15", bus.issue_wis, bus.issue_rd); end
    reset = 1'b1; #1;
    checks++; if (bus.issue_valid !== 1'b0 || bus.issue_rd !== 6'd0 || bus.issue_wis !== 2'd0 || bus.issue_wb !== 1'b0) begin
      errors++; $display("FAIL async_reset_issue got v=%b wis=%0d rd=%0d wb=%b exp all 0",
                         bus.issue_valid, bus.issue_wis, bus.issue_rd, bus.issue_wb); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL async_reset_pending got=%b exp=0000", bus.wis_pending); end
    checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL async_reset_stall got=%0d exp=0", bus.stall_cycles); end
    checks++; if (bus.ibuf_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready got=%b exp=0", bus.ibuf_ready); end
    @(negedge clk); reset = 1'b0; drive_instr(2, 0, 0, 5, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", bus.ibuf_ready); end
    @(negedge clk); idle();
  endtask

  task automatic test_zero_reg();
    @(negedge clk); drive_instr(0, 1, 0, 0, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL zero_rd_ready got=%b exp=1", bus.ibuf_ready); end
    @(negedge clk); drive_instr(0, 1, 0, 0, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL zero_rs_ready got=%b exp=1", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL zero_pending got=%b exp=0000", bus.wis_pending); end
    @(negedge clk); idle(); drive_wb(3, 9, 1);
    @(negedge clk); idle(); drive_instr(3, 1, 9, 9, 0, 0); #1;
    checks++; if (bus.ibuf_ready !== 1'b1) begin errors++; $display("FAIL spurious_wb_ready got=%b exp=1", bus.ibuf_ready); end
    checks++; if (bus.wis_pending !== 4'b0000) begin errors++; $display("FAIL spurious_wb_pending got=%b exp=0000", bus.wis_pending); end
    checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL zero_stall_count got=%0d exp=0", bus.stall_cycles); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.wis_pending !== 4'b1000) begin errors++; $display("FAIL spurious_then_set got=%b exp=1000", bus.wis_pending); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_multibeat();
    test_back_to_back();
    test_backpressure();
    test_cnt_full_and_reset();
    test_zero_reg();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
